// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential shift ALU.
package alu_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step: produces the next working value and the bit that leaves it.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r_next,
    output logic             bit_out
);

    always_comb begin
        r_next  = r;
        bit_out = 1'b0;
        case (op)
            OP_SHR: begin
                r_next  = {1'b0, r[WIDTH-1:1]};
                bit_out = r[0];
            end
            OP_SHL: begin
                r_next  = {r[WIDTH-2:0], 1'b0};
                bit_out = r[WIDTH-1];
            end
            OP_ROR: begin
                r_next  = {r[0], r[WIDTH-1:1]};
                bit_out = r[0];
            end
            default: begin
                // NOT finishes in the accept cycle, so it never reaches the step.
                r_next  = r;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_shift.sv
// Sequential NOT/SHR/SHL/ROR ALU: shifts iterate one bit per clock behind a valid/ready handshake.
module alu_seq_shift
    import alu_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             cf,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE, out_valid only in DONE; both are forced low while rst_n is low.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [1:0]       op_q, op_d;

    logic [WIDTH-1:0] step_r;
    logic             step_bit;
    logic [SHW-1:0]   n;
    logic             unused_b_hi;

    assign n           = b[SHW-1:0];
    assign unused_b_hi = ^b[WIDTH-1:SHW];

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .r       (result_q),
        .op      (op_q),
        .r_next  (step_r),
        .bit_out (step_bit)
    );

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = rst_n && (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT);
    assign result    = result_q;
    assign zf        = zf_q;
    assign cf        = cf_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        count_d  = count_q;
        op_d     = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    cf_d = 1'b0;
                    if (op == OP_NOT) begin
                        result_d = ~a;
                        state_d  = ST_DONE;
                    end else if (n == '0) begin
                        result_d = a;
                        state_d  = ST_DONE;
                    end else begin
                        result_d = a;
                        count_d  = n;
                        state_d  = ST_SHIFT;
                    end
                    zf_d = (result_d == '0);
                end
            end
            ST_SHIFT: begin
                result_d = step_r;
                cf_d     = step_bit;
                zf_d     = (step_r == '0);
                count_d  = count_q - 1'b1;
                if (count_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            count_q  <= '0;
            op_q     <= OP_NOT;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            count_q  <= count_d;
            op_q     <= op_d;
        end
    end

endmodule
